// File: rtl/fabric_ingress_arbiter_pkg.sv
// Shared types for the fabric ingress arbiter: arbiter state encoding and
// the default crossbar data width.
package fabric_ingress_arbiter_pkg;

   localparam int unsigned FABRIC_DATA_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ABORT,
      DRAIN
   } arb_state_t;

endpackage

// File: rtl/fabric_ingress_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first requester strictly
// after last_grant, wrapping around.
module fabric_rr_picker #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned SRC_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] requests,
   input  logic [SRC_WIDTH-1:0] last_grant,
   output logic [SRC_WIDTH-1:0] grant,
   output logic                 grant_valid
);

   logic [SRC_WIDTH-1:0] idx;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = '0;
      // Scan farthest-to-nearest so the nearest requester after last_grant
      // is the final (winning) assignment.
      for (int unsigned i = NUM_PORTS; i > 0; i--) begin
         idx = SRC_WIDTH'((32'(last_grant) + i) % NUM_PORTS);
         if (requests[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fabric_ingress_arbiter.sv
// Frame-granular round-robin arbiter onto the crossbar ingress with a
// registered output stage. Optional mid-frame watchdog: FABRIC_ARB_WATCHDOG_EN.
module fabric_ingress_arbiter
   import fabric_ingress_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned DATA_WIDTH = FABRIC_DATA_WIDTH,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned SRC_WIDTH  = $clog2(NUM_PORTS)
) (
   input  logic                              clk_fabric,
   input  logic                              rst,
   input  logic [NUM_PORTS-1:0]              in_tvalid,
   output logic [NUM_PORTS-1:0]              in_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   in_tdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] in_tkeep,
   input  logic [NUM_PORTS-1:0]              in_tlast,
   input  logic [NUM_PORTS-1:0]              in_tuser,
   output logic                              out_tvalid,
   input  logic                              out_tready,
   output logic [DATA_WIDTH-1:0]             out_tdata,
   output logic [DATA_WIDTH/8-1:0]           out_tkeep,
   output logic                              out_tlast,
   output logic                              out_tuser,
   output logic [SRC_WIDTH-1:0]              out_tsrc,
   output logic [15:0]                       abort_count
);

   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

   if (NUM_PORTS < 2 || TIMEOUT < 1 || TIMEOUT > 65536) begin : g_cfg_check
      $error("fabric_ingress_arbiter: unsupported NUM_PORTS/TIMEOUT");
   end

   arb_state_t             state, state_nxt;
   logic [SRC_WIDTH-1:0]   grant, pick;
   logic                   pick_valid;
   logic                   out_free, load_beat, load_abort, timed_out;
   logic                   sel_tvalid, sel_tlast, sel_tuser;
   logic [DATA_WIDTH-1:0]  sel_tdata;
   logic [KEEP_WIDTH-1:0]  sel_tkeep;

   // grant doubles as last_grant: it is only reloaded on an IDLE pass.
   fabric_rr_picker #(
      .NUM_PORTS (NUM_PORTS),
      .SRC_WIDTH (SRC_WIDTH)
   ) u_picker (
      .requests    (in_tvalid),
      .last_grant  (grant),
      .grant       (pick),
      .grant_valid (pick_valid)
   );

   assign sel_tvalid = in_tvalid[grant];
   assign sel_tlast  = in_tlast[grant];
   assign sel_tuser  = in_tuser[grant];
   assign sel_tdata  = in_tdata[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_tkeep  = in_tkeep[32'(grant)*KEEP_WIDTH +: KEEP_WIDTH];

   assign out_free  = !out_tvalid || out_tready;
   assign load_beat = (state == BUSY) && out_free && sel_tvalid;

`ifdef FABRIC_ARB_WATCHDOG_EN
   logic [15:0] idle_cnt;
   logic [15:0] abort_cnt;

   assign timed_out   = (state == BUSY) && !sel_tvalid && (idle_cnt == 16'(TIMEOUT - 1));
   assign load_abort  = (state == ABORT) && out_free;
   assign abort_count = abort_cnt;

   always_ff @(posedge clk_fabric) begin
      if (rst || state != state_nxt || state != BUSY || sel_tvalid) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk_fabric) begin
      if (rst) begin
         abort_cnt <= '0;
      end else if (load_abort && abort_cnt != '1) begin
         abort_cnt <= abort_cnt + 16'd1;
      end
   end
`else
   assign timed_out   = 1'b0;
   assign load_abort  = 1'b0;
   assign abort_count = '0;
`endif

   always_comb begin
      state_nxt = state;
      in_tready = '0;
      case (state)
         IDLE: begin
            if (pick_valid) state_nxt = BUSY;
         end
         BUSY: begin
            in_tready[grant] = out_free;
            if (load_beat && sel_tlast) state_nxt = IDLE;
            else if (timed_out)         state_nxt = ABORT;
         end
`ifdef FABRIC_ARB_WATCHDOG_EN
         ABORT: begin
            if (out_free) state_nxt = DRAIN;
         end
         DRAIN: begin
            in_tready[grant] = 1'b1;
            if (sel_tvalid && sel_tlast) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_fabric) begin
      if (rst) begin
         state <= IDLE;
         grant <= SRC_WIDTH'(NUM_PORTS - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_valid) grant <= pick;
      end
   end

   always_ff @(posedge clk_fabric) begin
      if (rst) begin
         out_tvalid <= 1'b0;
         out_tdata  <= '0;
         out_tkeep  <= '0;
         out_tlast  <= 1'b0;
         out_tuser  <= 1'b0;
         out_tsrc   <= '0;
      end else if (load_beat) begin
         out_tvalid <= 1'b1;
         out_tdata  <= sel_tdata;
         out_tkeep  <= sel_tkeep;
         out_tlast  <= sel_tlast;
         out_tuser  <= sel_tuser;
         out_tsrc   <= grant;
      end else if (load_abort) begin
         out_tvalid <= 1'b1;
         out_tdata  <= '0;
         out_tkeep  <= '0;
         out_tlast  <= 1'b1;
         out_tuser  <= 1'b1;
         out_tsrc   <= grant;
      end else if (out_tready) begin
         out_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fabric_ingress_arbiter.sv
// Scoreboard bench for fabric_ingress_arbiter: expected beats are queued on
// input acceptance and compared as they leave the output register.
module tb_fabric_ingress_arbiter;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int KW = DW / 8;
   localparam int SW = 2;

   logic              clk_fabric = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     in_tvalid, in_tready, in_tlast, in_tuser;
   logic [NP*DW-1:0]  in_tdata;
   logic [NP*KW-1:0]  in_tkeep;
   logic              out_tvalid, out_tready, out_tlast, out_tuser;
   logic [DW-1:0]     out_tdata;
   logic [KW-1:0]     out_tkeep;
   logic [SW-1:0]     out_tsrc;
   logic [15:0]       abort_count;

   logic              s_valid [NP];
   logic              s_last  [NP];
   logic              s_user  [NP];
   logic [DW-1:0]     s_data  [NP];
   logic [KW-1:0]     s_keep  [NP];

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
      logic [SW-1:0] src;
   } beat_t;

   beat_t sb [$];
   beat_t mon_e;
   int    pop_cyc [$];
   int    frame_src [$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    viol;
   bit    p_done;

   fabric_ingress_arbiter #(
      .NUM_PORTS  (NP),
      .DATA_WIDTH (DW),
      .TIMEOUT    (16)
   ) dut (
      .clk_fabric  (clk_fabric),
      .rst         (rst),
      .in_tvalid   (in_tvalid),
      .in_tready   (in_tready),
      .in_tdata    (in_tdata),
      .in_tkeep    (in_tkeep),
      .in_tlast    (in_tlast),
      .in_tuser    (in_tuser),
      .out_tvalid  (out_tvalid),
      .out_tready  (out_tready),
      .out_tdata   (out_tdata),
      .out_tkeep   (out_tkeep),
      .out_tlast   (out_tlast),
      .out_tuser   (out_tuser),
      .out_tsrc    (out_tsrc),
      .abort_count (abort_count)
   );

   always #5 clk_fabric = ~clk_fabric;
   always @(posedge clk_fabric) cyc <= cyc + 1;

   always_comb begin
      in_tvalid = '0;
      in_tlast  = '0;
      in_tuser  = '0;
      in_tdata  = '0;
      in_tkeep  = '0;
      for (int i = 0; i < NP; i++) begin
         in_tvalid[i]          = s_valid[i];
         in_tlast[i]           = s_last[i];
         in_tuser[i]           = s_user[i];
         in_tdata[i*DW +: DW]  = s_data[i];
         in_tkeep[i*KW +: KW]  = s_keep[i];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mk_data(input int p, input int f, input int b);
      return {8'(p), 8'(f), 16'(b), 32'(32'hC0DE_0000 + 32'(b * 17))};
   endfunction

   // Output monitor: handshake visible at negedge completes on the next posedge.
   always @(negedge clk_fabric) begin
      if (!rst && out_tvalid && out_tready) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", {48'd0, out_tdata[63:48]}, 64'hDEAD);
         end else begin
            mon_e = sb.pop_front();
            check("tdata", out_tdata, mon_e.data);
            check("tkeep", 64'(out_tkeep), 64'(mon_e.keep));
            check("tlast", 64'(out_tlast), 64'(mon_e.last));
            check("tuser", 64'(out_tuser), 64'(mon_e.user));
            check("tsrc",  64'(out_tsrc),  64'(mon_e.src));
         end
         pop_cyc.push_back(cyc);
         if (out_tlast) frame_src.push_back(int'(out_tsrc));
      end
   end

   task automatic send_beats(input int p, input int f, input int b0, input int b1,
                             input int n, input bit push);
      beat_t e;
      int    guard;
      bit    got;
      for (int b = b0; b <= b1; b++) begin
         s_valid[p] = 1'b1;
         s_data[p]  = mk_data(p, f, b);
         s_keep[p]  = (b == n - 1) ? 8'h3F : 8'hFF;
         s_last[p]  = (b == n - 1);
         s_user[p]  = (b == n - 1) && (f % 2 == 1);
         got   = 1'b0;
         guard = 0;
         while (!got && guard < 2000) begin
            @(negedge clk_fabric);
            if (in_tready[p]) begin
               got = 1'b1;
               if (push) begin
                  e.data = s_data[p];
                  e.keep = s_keep[p];
                  e.last = s_last[p];
                  e.user = s_user[p];
                  e.src  = SW'(p);
                  sb.push_back(e);
               end
            end
            guard++;
            @(posedge clk_fabric); #1;
         end
         if (!got) check("accept_timeout", 64'(got), 64'd1);
      end
      s_valid[p] = 1'b0;
      s_last[p]  = 1'b0;
      s_user[p]  = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int g = 0;
      while ((sb.size() != 0 || out_tvalid) && g < max_cyc) begin
         @(posedge clk_fabric);
         g++;
      end
      if (g >= max_cyc) check("drain_timeout", 64'(sb.size()), 64'd0);
      @(posedge clk_fabric); #1;
   endtask

   task automatic check_order(input string tag, input int a, input int b);
      check({tag, "_frames"}, 64'(frame_src.size()), 64'd2);
      if (frame_src.size() == 2) begin
         check({tag, "_first"},  64'(frame_src[0]), 64'(a));
         check({tag, "_second"}, 64'(frame_src[1]), 64'(b));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      beat_t ab;
      int    b;
      int    g;
      for (int i = 0; i < NP; i++) begin
         s_valid[i] = 1'b0;
         s_last[i]  = 1'b0;
         s_user[i]  = 1'b0;
         s_data[i]  = '0;
         s_keep[i]  = '0;
      end
      out_tready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk_fabric);
      @(negedge clk_fabric);
      check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
      check("rst_in_tready", 64'(in_tready), 64'd0);
      check("rst_abort_count", 64'(abort_count), 64'd0);
      @(posedge clk_fabric); #1;
      rst = 1'b0;

      // Two streams, three back-to-back frames each: strict 0,2 alternation.
      frame_src.delete();
      pop_cyc.delete();
      fork
         for (int f = 0; f < 3; f++) send_beats(0, f, 0, 7, 8, 1'b1);
         for (int f = 0; f < 3; f++) send_beats(2, 10 + f, 0, 7, 8, 1'b1);
      join
      drain(200);
      check("t1_frames", 64'(frame_src.size()), 64'd6);
      if (frame_src.size() == 6) begin
         for (int i = 0; i < 6; i++) check("t1_order", 64'(frame_src[i]), (i % 2 == 0) ? 64'd0 : 64'd2);
      end
      check("t1_beats", 64'(pop_cyc.size()), 64'd48);
      if (pop_cyc.size() == 48) check("t1_span", 64'(pop_cyc[47] - pop_cyc[0]), 64'd52);

      // Late requester must wait for the in-flight frame to finish.
      frame_src.delete();
      viol   = 0;
      p_done = 1'b0;
      fork
         begin send_beats(1, 20, 0, 5, 6, 1'b1); p_done = 1'b1; end
         begin repeat (3) @(posedge clk_fabric); #1; send_beats(3, 21, 0, 3, 4, 1'b1); end
         begin
            int k = 0;
            while (!p_done && k < 500) begin
               @(negedge clk_fabric);
               if (in_tready[3]) viol++;
               k++;
            end
         end
      join
      drain(200);
      check("t2_p3_ready_held", 64'(viol), 64'd0);
      check_order("t2", 1, 3);

      // Downstream backpressure toggling every cycle.
      pop_cyc.delete();
      fork
         send_beats(2, 30, 0, 15, 16, 1'b1);
         begin
            for (int k = 0; k < 60; k++) begin
               out_tready = ~out_tready;
               @(posedge clk_fabric); #1;
            end
            out_tready = 1'b1;
         end
      join
      drain(200);
      check("t3_beats", 64'(pop_cyc.size()), 64'd16);

      // Reset mid-frame on port 2, then ports 0 and 3 contend.
      b = 0;
      g = 0;
      s_valid[2] = 1'b1;
      while (b < 4 && g < 200) begin
         s_data[2] = mk_data(2, 40, b);
         s_keep[2] = 8'hFF;
         s_last[2] = 1'b0;
         s_user[2] = 1'b0;
         @(negedge clk_fabric);
         if (in_tready[2]) begin
            ab.data = s_data[2]; ab.keep = 8'hFF; ab.last = 1'b0; ab.user = 1'b0; ab.src = 2'd2;
            sb.push_back(ab);
            b++;
         end
         g++;
         @(posedge clk_fabric); #1;
      end
      check("t4_beats_sent", 64'(b), 64'd4);
      rst = 1'b1;
      s_valid[2] = 1'b0;
      @(posedge clk_fabric);
      @(negedge clk_fabric);
      check("t4_out_tvalid", 64'(out_tvalid), 64'd0);
      check("t4_out_tlast",  64'(out_tlast),  64'd0);
      check("t4_out_tuser",  64'(out_tuser),  64'd0);
      check("t4_out_tdata",  out_tdata,       64'd0);
      check("t4_out_tkeep",  64'(out_tkeep),  64'd0);
      check("t4_out_tsrc",   64'(out_tsrc),   64'd0);
      check("t4_in_tready",  64'(in_tready),  64'd0);
      check("t4_abort_count", 64'(abort_count), 64'd0);
      sb.delete();
      @(posedge clk_fabric); #1;
      rst = 1'b0;
      frame_src.delete();
      fork
         send_beats(3, 41, 0, 1, 2, 1'b1);
         send_beats(0, 42, 0, 1, 2, 1'b1);
      join
      drain(200);
      check_order("t4", 0, 3);

      // Single requester is re-granted every frame.
      frame_src.delete();
      for (int f = 0; f < 2; f++) send_beats(1, 45 + f, 0, 2, 3, 1'b1);
      drain(200);
      check_order("t5", 1, 1);

`ifdef FABRIC_ARB_WATCHDOG_EN
      // Port 0 stalls mid-frame for longer than TIMEOUT: abort beat, drain, then port 1.
      frame_src.delete();
      pop_cyc.delete();
      fork
         begin
            send_beats(0, 60, 0, 2, 8, 1'b1);
            ab.data = '0; ab.keep = '0; ab.last = 1'b1; ab.user = 1'b1; ab.src = 2'd0;
            sb.push_back(ab);
            repeat (30) @(posedge clk_fabric); #1;
            send_beats(0, 60, 3, 7, 8, 1'b0);
         end
         begin repeat (2) @(posedge clk_fabric); #1; send_beats(1, 61, 0, 4, 5, 1'b1); end
      join
      drain(200);
      check("t6_abort_count", 64'(abort_count), 64'd1);
      check("t6_beats", 64'(pop_cyc.size()), 64'd9);
      if (pop_cyc.size() == 9) check("t6_abort_delay", 64'(pop_cyc[3] - pop_cyc[2]), 64'd17);
      check_order("t6", 0, 1);
`else
      // Port 0 stalls mid-frame: grant is held, port 1 waits for tlast.
      frame_src.delete();
      viol   = 0;
      p_done = 1'b0;
      fork
         begin
            send_beats(0, 50, 0, 2, 8, 1'b1);
            repeat (40) @(posedge clk_fabric); #1;
            send_beats(0, 50, 3, 7, 8, 1'b1);
            p_done = 1'b1;
         end
         begin repeat (2) @(posedge clk_fabric); #1; send_beats(1, 51, 0, 3, 4, 1'b1); end
         begin
            int k = 0;
            while (!p_done && k < 500) begin
               @(negedge clk_fabric);
               if (in_tready[1]) viol++;
               k++;
            end
         end
      join
      drain(200);
      check("t6_p1_ready_held", 64'(viol), 64'd0);
      check("t6_abort_count", 64'(abort_count), 64'd0);
      check_order("t6", 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
